// File: rtl/mdu_if.sv
// MDU request/result bundle: operation launch, MTHI/MTLO writes and HI/LO readback.
interface mdu_if;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        HIWrite;
  logic        LOWrite;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, Op, A, B, HIWrite, LOWrite,
    input  Busy, HI, LO
  );

  modport slave (
    input  Start, Op, A, B, HIWrite, LOWrite,
    output Busy, HI, LO
  );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// An operation latches its operands on Start, holds Busy for a fixed
// number of cycles and commits the full result on the final edge.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  Reset,
  mdu_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] mul_res;
  logic [63:0] div_res;

  // 64-bit product; both flavours share one signed 66-bit multiply by
  // sign- or zero-extending the operands first.
  function automatic logic [63:0] mul_full(input logic [31:0] a, input logic [31:0] b,
                                           input logic uns);
    logic signed [65:0] sa, sb, prod;
    sa   = uns ? $signed({34'b0, a}) : 66'($signed(a));
    sb   = uns ? $signed({34'b0, b}) : 66'($signed(b));
    prod = sa * sb;
    return prod[63:0];
  endfunction

  // {remainder, quotient}. A 33-bit signed divide covers both flavours and
  // keeps 0x80000000 / -1 representable (quotient 2^31 wraps to 0x80000000).
  function automatic logic [63:0] div_full(input logic [31:0] a, input logic [31:0] b,
                                           input logic uns);
    logic signed [32:0] sa, sb, q, r;
    sa = uns ? $signed({1'b0, a}) : $signed({a[31], a});
    sb = uns ? $signed({1'b0, b}) : $signed({b[31], b});
    if (sb == 33'sd0) begin
      q = 33'sd0;
      r = 33'sd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {r[31:0], q[31:0]};
  endfunction

  assign mul_res  = mul_full(a_q, b_q, op_q[0]);
  assign div_res  = div_full(a_q, b_q, op_q[0]);
  assign bus.Busy = (state_q != IDLE);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

  // Next-state logic: launch, count down, commit; MTHI/MTLO only when idle
  // and only if no Start competes in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          op_d    = bus.Op;
          state_d = bus.Op[1] ? DIV : MUL;
          cnt_d   = bus.Op[1] ? DIV_N : MULT_N;
        end else begin
          if (bus.HIWrite) hi_d = bus.A;
          if (bus.LOWrite) lo_d = bus.A;
        end
      end
      MUL, DIV: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          if (state_q == MUL) begin
            {hi_d, lo_d} = mul_res;
          end else if (b_q != 32'd0) begin
            {hi_d, lo_d} = div_res;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter, latched operands and HI/LO; reset aborts any operation.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 2'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu against an arithmetic reference model.
module tb_mdu;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic Reset;
  mdu_if bus ();

  mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference result {HI,LO} computed with plain 64-bit integer arithmetic.
  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          x, y, q, r;
    longint unsigned ux, uy;
    logic [31:0]     uq, ur;
    case (op)
      2'b00: begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        return 64'(x * y);
      end
      2'b01: begin
        ux = {32'b0, a};
        uy = {32'b0, b};
        return 64'(ux * uy);
      end
      2'b10: begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
      end
      default: begin
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic mt(input logic hiw, input logic low, input logic [31:0] d);
    bus.HIWrite = hiw;
    bus.LOWrite = low;
    bus.A       = d;
    @(negedge clk);
    bus.HIWrite = 1'b0;
    bus.LOWrite = 1'b0;
    if (hiw) hi_m = d;
    if (low) lo_m = d;
    chk("mt_busy", 64'(bus.Busy), 64'd0);
    chk("mt_hi", 64'(bus.HI), 64'(hi_m));
    chk("mt_lo", 64'(bus.LO), 64'(lo_m));
  endtask

  // Launch one operation (optionally with LOWrite in the launch cycle and
  // with disturbing traffic on every input while busy), then check the
  // busy length and the committed HI/LO on the first idle cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit noise, input bit lo_too);
    int          n;
    logic [63:0] r;
    bus.Op      = op;
    bus.A       = a;
    bus.B       = b;
    bus.Start   = 1'b1;
    bus.LOWrite = lo_too;
    @(negedge clk);
    bus.Start   = 1'b0;
    bus.LOWrite = 1'b0;
    chk("busy_rise", 64'(bus.Busy), 64'd1);
    n = 1;
    while (bus.Busy && n < 40) begin
      if (noise) begin
        bus.A       = $urandom;
        bus.B       = $urandom;
        bus.Op      = 2'($urandom);
        bus.Start   = 1'b1;
        bus.HIWrite = 1'b1;
        bus.LOWrite = 1'b1;
      end
      @(negedge clk);
      if (bus.Busy) n++;
    end
    bus.Start   = 1'b0;
    bus.HIWrite = 1'b0;
    bus.LOWrite = 1'b0;
    if (!(op[1] && b == 32'd0)) begin
      r = ref_res(op, a, b);
      hi_m = r[63:32];
      lo_m = r[31:0];
    end
    chk("busy_cycles", 64'(n), op[1] ? 64'(DIV_N) : 64'(MULT_N));
    chk("op_hi", 64'(bus.HI), 64'(hi_m));
    chk("op_lo", 64'(bus.LO), 64'(lo_m));
  endtask

  initial begin
    Reset       = 1'b0;
    bus.Start   = 1'b0;
    bus.Op      = 2'd0;
    bus.A       = 32'd0;
    bus.B       = 32'd0;
    bus.HIWrite = 1'b0;
    bus.LOWrite = 1'b0;
    #1;
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_hi", 64'(bus.HI), 64'd0);
    chk("rst_lo", 64'(bus.LO), 64'd0);
    repeat (3) @(negedge clk);
    Reset = 1'b1;

    // signed multiply
    do_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b0);
    chk("mult_hi_k", 64'(bus.HI), 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo_k", 64'(bus.LO), 64'h0000_0000_FFFF_FFFA);

    // unsigned multiply followed immediately by unsigned divide
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("multu_hi_k", 64'(bus.HI), 64'h0000_0000_FFFF_FFFE);
    chk("multu_lo_k", 64'(bus.LO), 64'h0000_0000_0000_0001);
    do_op(2'b11, 32'd7, 32'd2, 1'b0, 1'b0);
    chk("divu_hi_k", 64'(bus.HI), 64'd1);
    chk("divu_lo_k", 64'(bus.LO), 64'd3);

    // signed divide, then divide by zero
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_hi_k", 64'(bus.HI), 64'h0000_0000_FFFF_FFFF);
    chk("div_lo_k", 64'(bus.LO), 64'h0000_0000_FFFF_FFFD);
    do_op(2'b10, 32'd5, 32'd0, 1'b0, 1'b0);
    chk("div0_hi_k", 64'(bus.HI), 64'h0000_0000_FFFF_FFFF);
    chk("div0_lo_k", 64'(bus.LO), 64'h0000_0000_FFFF_FFFD);

    // most-negative / -1
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("ovf_hi_k", 64'(bus.HI), 64'd0);
    chk("ovf_lo_k", 64'(bus.LO), 64'h0000_0000_8000_0000);

    // MTLO/MTHI, then writes while busy and together with Start are dropped
    mt(1'b0, 1'b1, 32'hCAFE_F00D);
    mt(1'b1, 1'b0, 32'h1234_5678);
    do_op(2'b10, 32'd9, 32'd0, 1'b1, 1'b1);
    chk("mthi_k", 64'(bus.HI), 64'h0000_0000_1234_5678);
    chk("mtlo_keep_k", 64'(bus.LO), 64'h0000_0000_CAFE_F00D);
    mt(1'b1, 1'b1, 32'h0BAD_BEEF);

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0)
        mt(1'($urandom), 1'($urandom), $urandom);
      else
        do_op(2'($urandom), pick(), pick(), 1'($urandom), 1'($urandom));
    end

    // asynchronous reset in the middle of a divide
    bus.Op    = 2'b10;
    bus.A     = 32'd100;
    bus.B     = 32'd7;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    #2 Reset = 1'b0;
    #1;
    hi_m = 32'd0;
    lo_m = 32'd0;
    chk("arst_busy", 64'(bus.Busy), 64'd0);
    chk("arst_hi", 64'(bus.HI), 64'd0);
    chk("arst_lo", 64'(bus.LO), 64'd0);
    @(negedge clk);
    Reset = 1'b1;
    mt(1'b1, 1'b0, 32'h5555_AAAA);
    repeat (12) @(negedge clk);
    chk("post_rst_busy", 64'(bus.Busy), 64'd0);
    chk("post_rst_hi", 64'(bus.HI), 64'h0000_0000_5555_AAAA);
    chk("post_rst_lo", 64'(bus.LO), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
